// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enabled writes and a power-up clear
// sequence that zeroes every entry before the ports are released.
//
// state   | meaning
// S_CLEAR | zeroing one entry per cycle from the pointer; writes dropped, reads return 0
// S_READY | normal operation; byte-enabled writes, N_RD independent reads
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int N_RD     = 2,
   parameter int RD_REG   = 0,
   parameter int ZERO_REG = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic [DATA_W/8-1:0]    wr_be,
   input  logic [N_RD*ADDR_W-1:0] rd_addr,
   output logic [N_RD*DATA_W-1:0] rd_data,
   output logic                   init_busy
);

   localparam int                NB       = DATA_W / 8;
   localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [DATA_W-1:0] mem_q  [DEPTH];
   logic [DATA_W-1:0] rd_q   [N_RD];
   logic [DATA_W-1:0] rd_d   [N_RD];
   logic [DATA_W-1:0] rd_cur [N_RD];
   logic              busy;
   logic              wr_ok;
   logic [ADDR_W-1:0] wr_idx;
   logic [DATA_W-1:0] wr_word_d;

   // An address is usable when it lies inside the array and is not the
   // hardwired-zero entry.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] upd,
                                                    input logic [NB-1:0]     be);
      logic [DATA_W-1:0] r;
      r = cur;
      for (int k = 0; k < NB; k++) begin
         if (be[k]) r[8*k +: 8] = upd[8*k +: 8];
      end
      return r;
   endfunction

   // Reset counts as busy so the ports are blocked in the reset cycle itself.
   assign busy      = reset || (state_q == S_CLEAR);
   assign init_busy = busy;

   // Clear sequencer: walk the pointer across the array, then release.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_CLEAR;
         ptr_q   <= '0;
      end else if (state_q == S_CLEAR) begin
         if (ptr_q == LAST_PTR) begin
            state_q <= S_READY;
            ptr_q   <= '0;
         end else begin
            ptr_q <= ptr_q + 1'b1;
         end
      end
   end

   // Qualify the write and build the merged word for the target entry.
   always_comb begin
      wr_ok     = !busy && wr_en && addr_ok(wr_addr);
      wr_idx    = wr_ok ? wr_addr : '0;
      wr_word_d = byte_merge(mem_q[wr_idx], wr_data, wr_be);
   end

   // Storage array: clear writes take the pointer, normal writes the merged word.
   always_ff @(posedge clk) begin
      if (!reset && (state_q == S_CLEAR)) begin
         mem_q[ptr_q] <= '0;
      end else if (wr_ok) begin
         mem_q[wr_idx] <= wr_word_d;
      end
   end

   // Per-port read: current contents, plus write-first view for the registered path.
   always_comb begin
      for (int p = 0; p < N_RD; p++) begin
         rd_cur[p] = (!busy && addr_ok(rd_addr[p*ADDR_W +: ADDR_W]))
                     ? mem_q[rd_addr[p*ADDR_W +: ADDR_W]] : '0;
         rd_d[p]   = (wr_ok && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W]))
                     ? byte_merge(rd_cur[p], wr_data, wr_be) : rd_cur[p];
      end
   end

   // Registered read data, only observed when RD_REG is set.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int p = 0; p < N_RD; p++) rd_q[p] <= '0;
      end else begin
         for (int p = 0; p < N_RD; p++) rd_q[p] <= rd_d[p];
      end
   end

   // Output select, forced to zero whenever the block is busy.
   always_comb begin
      rd_data = '0;
      for (int p = 0; p < N_RD; p++) begin
         rd_data[p*DATA_W +: DATA_W] = busy ? '0 : ((RD_REG != 0) ? rd_q[p] : rd_cur[p]);
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: combinational and registered-read instances share
// stimulus against a word-array model; a third instance covers DEPTH=24,
// ZERO_REG=1, N_RD=3.
module tb_regfile_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data_c, rd_data_r;
   logic        busy_c, busy_r;

   logic        rst_e, we_e;
   logic [4:0]  wa_e;
   logic [31:0] wd_e;
   logic [3:0]  wbe_e;
   logic [14:0] ra_e;
   logic [95:0] rd_e;
   logic        busy_e;

   regfile_mp #(.RD_REG(0)) u_comb (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_addr(rd_addr), .rd_data(rd_data_c), .init_busy(busy_c));

   regfile_mp #(.RD_REG(1)) u_reg (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_addr(rd_addr), .rd_data(rd_data_r), .init_busy(busy_r));

   regfile_mp #(.DEPTH(24), .N_RD(3), .ZERO_REG(1)) u_edge (
      .clk(clk), .reset(rst_e), .wr_en(we_e), .wr_addr(wa_e), .wr_data(wd_e),
      .wr_be(wbe_e), .rd_addr(ra_e), .rd_data(rd_e), .init_busy(busy_e));

   int errors = 0;
   int checks = 0;
   logic [31:0] model [32];

   typedef struct {
      logic        en;
      logic [4:0]  a;
      logic [31:0] d;
      logic [3:0]  be;
      logic [4:0]  r0, r1;
      logic [31:0] c0, c1, q0, q1;
   } vec_t;
   vec_t tbl [6];

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_write(input logic en, input logic [4:0] a,
                              input logic [31:0] d, input logic [3:0] be);
      if (en) begin
         for (int k = 0; k < 4; k++) begin
            if (be[k]) model[a][8*k +: 8] = d[8*k +: 8];
         end
      end
   endtask

   // Called at a negedge; returns combinational data seen before the edge and
   // registered data seen after it, ending on the following negedge.
   task automatic step(input logic en, input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [4:0] r0, input logic [4:0] r1,
                       output logic [31:0] c0, output logic [31:0] c1,
                       output logic [31:0] q0, output logic [31:0] q1);
      wr_en = en; wr_addr = a; wr_data = d; wr_be = be; rd_addr = {r1, r0};
      #1;
      c0 = rd_data_c[31:0];
      c1 = rd_data_c[63:32];
      @(posedge clk);
      @(negedge clk);
      q0 = rd_data_r[31:0];
      q1 = rd_data_r[63:32];
      wr_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wr_en = 1'b0;
      #1;
      check("busy_in_reset_c", busy_c, 1);
      check("busy_in_reset_r", busy_r, 1);
      check("rd_in_reset_c", rd_data_c, 0);
      check("rd_in_reset_r", rd_data_r, 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Counts busy cycles after reset release; optionally injects a write mid-clear.
   task automatic count_busy(input bit inject, output int nc, output int nr);
      int n;
      n = 0; nc = 0; nr = 0;
      while ((busy_c === 1'b1 || busy_r === 1'b1) && n < 100) begin
         if (busy_c === 1'b1) nc++;
         if (busy_r === 1'b1) nr++;
         if (n == 3) begin
            check("rd_zero_in_clear_c", rd_data_c, 0);
            check("rd_zero_in_clear_r", rd_data_r, 0);
         end
         if (inject && n == 5) begin
            wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
         end else begin
            wr_en = 1'b0;
         end
         n++;
         @(negedge clk);
      end
      wr_en = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] c0, c1, q0, q1, o0, o1, n0, n1, e0, e1;
      logic [31:0] kmul;
      logic        en;
      logic [4:0]  a, r0, r1;
      logic [31:0] d;
      logic [3:0]  be;
      int nc, nr, ne;

      kmul = 32'h24082745;
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = {5'd3, 5'd3};
      rst_e = 1'b1; we_e = 1'b0; wa_e = '0; wd_e = '0; wbe_e = '0; ra_e = '0;
      for (int i = 0; i < 32; i++) model[i] = '0;

      tbl[0] = '{1'b1, 5'd5, 32'hFFFFFFFF, 4'hF,    5'd5, 5'd7, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0};
      tbl[1] = '{1'b1, 5'd5, 32'h12345678, 4'b0101, 5'd5, 5'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFF34FF78, 32'hFF34FF78};
      tbl[2] = '{1'b1, 5'd7, 32'hA5A5A5A5, 4'hF,    5'd5, 5'd7, 32'hFF34FF78, 32'h0,        32'hFF34FF78, 32'hA5A5A5A5};
      tbl[3] = '{1'b0, 5'd7, 32'h0,        4'hF,    5'd7, 5'd5, 32'hA5A5A5A5, 32'hFF34FF78, 32'hA5A5A5A5, 32'hFF34FF78};
      tbl[4] = '{1'b1, 5'd7, 32'h0,        4'h0,    5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
      tbl[5] = '{1'b1, 5'd7, 32'h00000011, 4'b0001, 5'd7, 5'd5, 32'hA5A5A5A5, 32'hFF34FF78, 32'hA5A5A511, 32'hFF34FF78};

      @(negedge clk);
      do_reset();
      count_busy(1'b0, nc, nr);
      check("clear_cycles_c", nc, 32);
      check("clear_cycles_r", nr, 32);

      for (int i = 0; i < 32; i++) begin
         step(1'b0, 5'd0, 32'h0, 4'h0, 5'(i), 5'(31 - i), c0, c1, q0, q1);
         check("cleared_c", {c1, c0}, 64'h0);
         check("cleared_r", {q1, q0}, 64'h0);
      end

      for (int i = 0; i < 6; i++) begin
         model_write(tbl[i].en, tbl[i].a, tbl[i].d, tbl[i].be);
         step(tbl[i].en, tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].r0, tbl[i].r1, c0, c1, q0, q1);
         check($sformatf("vec%0d_comb", i), {c1, c0}, {tbl[i].c1, tbl[i].c0});
         check($sformatf("vec%0d_reg", i),  {q1, q0}, {tbl[i].q1, tbl[i].q0});
      end

      for (int i = 0; i < 32; i++) begin
         o0 = model[i]; o1 = model[(i + 31) % 32];
         model_write(1'b1, 5'(i), kmul * 32'(i), 4'hF);
         n0 = model[i]; n1 = model[(i + 31) % 32];
         step(1'b1, 5'(i), kmul * 32'(i), 4'hF, 5'(i), 5'((i + 31) % 32), c0, c1, q0, q1);
         check("fill_comb", {c1, c0}, {o1, o0});
         check("fill_reg",  {q1, q0}, {n1, n0});
      end
      for (int i = 0; i < 32; i++) begin
         e0 = kmul * 32'((i + 31) % 32);
         e1 = kmul * 32'(i);
         step(1'b0, 5'd0, 32'h0, 4'h0, 5'((i + 31) % 32), 5'(i), c0, c1, q0, q1);
         check("readback_comb", {c1, c0}, {e1, e0});
         check("readback_reg",  {q1, q0}, {e1, e0});
      end

      for (int i = 0; i < 300; i++) begin
         en = 1'($urandom_range(0, 1));
         a  = 5'($urandom_range(0, 31));
         d  = $urandom;
         be = 4'($urandom_range(0, 15));
         r0 = 5'($urandom_range(0, 31));
         r1 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
         o0 = model[r0]; o1 = model[r1];
         model_write(en, a, d, be);
         n0 = model[r0]; n1 = model[r1];
         step(en, a, d, be, r0, r1, c0, c1, q0, q1);
         check("rand_comb", {c1, c0}, {o1, o0});
         check("rand_reg",  {q1, q0}, {n1, n0});
      end

      // Reset again ten cycles into a clear; the clear must restart and a
      // write issued during it must be lost.
      rd_addr = {5'd3, 5'd3};
      do_reset();
      for (int i = 0; i < 10; i++) @(negedge clk);
      check("midclear_busy", {busy_r, busy_c}, 2'b11);
      do_reset();
      count_busy(1'b1, nc, nr);
      check("restart_cycles_c", nc, 32);
      check("restart_cycles_r", nr, 32);
      for (int i = 0; i < 32; i++) model[i] = '0;
      step(1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd31, c0, c1, q0, q1);
      check("dropped_write_comb", {c1, c0}, 64'h0);
      check("dropped_write_reg",  {q1, q0}, 64'h0);

      // Non-power-of-two depth, hardwired zero entry, three read ports.
      rst_e = 1'b1;
      @(negedge clk);
      rst_e = 1'b0;
      ne = 0;
      while (busy_e === 1'b1 && ne < 100) begin
         ne++;
         @(negedge clk);
      end
      check("edge_clear_cycles", ne, 24);
      we_e = 1'b1; wbe_e = 4'hF;
      wa_e = 5'd0;  wd_e = 32'h11111111; @(negedge clk);
      wa_e = 5'd30; wd_e = 32'h22222222; @(negedge clk);
      wa_e = 5'd23; wd_e = 32'h0BADF00D; @(negedge clk);
      wa_e = 5'd24; wd_e = 32'h33333333; @(negedge clk);
      we_e = 1'b0;
      ra_e = {5'd30, 5'd0, 5'd23}; #1;
      check("edge_mixed", rd_e, {32'h0, 32'h0, 32'h0BADF00D});
      ra_e = {5'd23, 5'd23, 5'd23}; #1;
      check("edge_all_23", rd_e, {3{32'h0BADF00D}});
      ra_e = {5'd24, 5'd22, 5'd0}; #1;
      check("edge_oob_zero", rd_e, 96'h0);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
